// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: fetch defaults, fetch state encoding
// and instruction field accessors.
package cpu_pkg;

    localparam logic [15:0] DEFAULT_RESET_PC    = 16'h0000;
    localparam logic [15:0] DEFAULT_PC_STEP     = 16'd4;
    localparam logic [3:0]  DEFAULT_HALT_OPCODE = 4'hF;
    localparam logic [15:0] DEFAULT_NOP_INSTR   = 16'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    function automatic logic [3:0] opcode(input logic [15:0] instr);
        return instr[15:12];
    endfunction

    function automatic logic [3:0] rd(input logic [15:0] instr);
        return instr[11:8];
    endfunction

    function automatic logic [3:0] rs(input logic [15:0] instr);
        return instr[7:4];
    endfunction

    function automatic logic [3:0] rt(input logic [15:0] instr);
        return instr[3:0];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its address, address + step and a
// valid bit. Flush beats load; neither asserted means hold.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_in,
    input  logic [15:0] pc_plus_in,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [15:0] pc_plus,
    output logic        valid
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            instr   <= NOP_INSTR;
            pc      <= 16'h0000;
            pc_plus <= 16'h0000;
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= instr_in;
            pc      <= pc_in;
            pc_plus <= pc_plus_in;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, RUN/HALTED control, IF/ID register
// and a saturating count of latched instructions.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [15:0] PC_STEP     = DEFAULT_PC_STEP,
    parameter logic [3:0]  HALT_OPCODE = DEFAULT_HALT_OPCODE,
    parameter logic [15:0] NOP_INSTR   = DEFAULT_NOP_INSTR
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [15:0] RedirectPC,
    output logic [15:0] PC,
    input  logic [15:0] Instruction,
    output logic [15:0] IfIdInstr,
    output logic [15:0] IfIdPC,
    output logic [15:0] IfIdPCPlus,
    output logic        IfIdValid,
    output logic        Halted,
    output logic [15:0] FetchCount
);

    localparam logic [15:0] ALIGN_MASK = 16'hFFFC;

    fetch_state_e state, state_next;
    logic [15:0]  pc_next, pc_plus, count_next;
    logic         load, flush, halt_commit;

    assign pc_plus     = PC + PC_STEP;
    assign halt_commit = IfIdValid && (opcode(IfIdInstr) == HALT_OPCODE)
                         && !Stall && !Redirect;

    // NOTE: every always_comb output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = PC;
        count_next = FetchCount;
        load       = 1'b0;
        flush      = 1'b0;
        if (state == RUN) begin
            if (Redirect) begin
                pc_next = RedirectPC & ALIGN_MASK;
                flush   = 1'b1;
            end else if (halt_commit) begin
                state_next = HALTED;
                pc_next    = IfIdPCPlus;
                flush      = 1'b1;
            end else if (!Stall) begin
                load    = 1'b1;
                pc_next = pc_plus;
                if (FetchCount != 16'hFFFF)
                    count_next = FetchCount + 16'd1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= RUN;
            PC         <= RESET_PC;
            FetchCount <= 16'h0000;
        end else begin
            state      <= state_next;
            PC         <= pc_next;
            FetchCount <= count_next;
        end
    end

    assign Halted = (state == HALTED);

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk       (Clock),
        .reset     (Reset),
        .load      (load),
        .flush     (flush),
        .instr_in  (Instruction),
        .pc_in     (PC),
        .pc_plus_in(pc_plus),
        .instr     (IfIdInstr),
        .pc        (IfIdPC),
        .pc_plus   (IfIdPCPlus),
        .valid     (IfIdValid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-owned instruction memory, a
// scoreboard of expected IF/ID contents, and one task per scenario.
module tb_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset, Stall, Redirect;
    logic [15:0] RedirectPC, PC, Instruction;
    logic [15:0] IfIdInstr, IfIdPC, IfIdPCPlus, FetchCount;
    logic        IfIdValid, Halted;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_plus;
    } ifid_t;

    ifid_t       sb[$];
    logic [15:0] exp_pc;
    logic [15:0] exp_count;
    int          checks = 0;
    int          errors = 0;

    fetch_unit dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .PC         (PC),
        .Instruction(Instruction),
        .IfIdInstr  (IfIdInstr),
        .IfIdPC     (IfIdPC),
        .IfIdPCPlus (IfIdPCPlus),
        .IfIdValid  (IfIdValid),
        .Halted     (Halted),
        .FetchCount (FetchCount)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] imem(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0004: return 16'h2345;
            16'h0008: return 16'h3456;
            16'h000C: return 16'hF000;
            16'h0040: return 16'h4040;
            16'h0044: return 16'h4044;
            16'hFFFC: return 16'h5FFC;
            default:  return 16'h0000;
        endcase
    endfunction

    assign Instruction = imem(PC);

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Normal fetch cycles: push the expected IF/ID entry when driving, pop
    // and compare once the edge has latched it.
    task automatic fetch_cycles(input int n, input string tag);
        ifid_t e;
        for (int i = 0; i < n; i++) begin
            Stall    = 1'b0;
            Redirect = 1'b0;
            sb.push_back('{imem(exp_pc), exp_pc, exp_pc + 16'd4});
            step();
            exp_pc    = exp_pc + 16'd4;
            exp_count = exp_count + 16'd1;
            e = sb.pop_front();
            checks++;
            if (IfIdInstr !== e.instr || IfIdPC !== e.pc || IfIdPCPlus !== e.pc_plus
                || IfIdValid !== 1'b1) begin
                errors++;
                $display("FAIL %s ifid[%0d]: got instr=%h pc=%h plus=%h v=%b, want %h %h %h 1",
                         tag, i, IfIdInstr, IfIdPC, IfIdPCPlus, IfIdValid,
                         e.instr, e.pc, e.pc_plus);
            end
            checks++;
            if (PC !== exp_pc || FetchCount !== exp_count || Halted !== 1'b0) begin
                errors++;
                $display("FAIL %s pc/count[%0d]: got pc=%h cnt=%0d h=%b, want %h %0d 0",
                         tag, i, PC, FetchCount, Halted, exp_pc, exp_count);
            end
        end
    endtask

    task automatic test_reset();
        Reset      = 1'b1;
        Stall      = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 16'h0000;
        step();
        checks++;
        if (PC !== 16'h0000 || IfIdInstr !== 16'h0000 || IfIdPC !== 16'h0000
            || IfIdPCPlus !== 16'h0000 || IfIdValid !== 1'b0 || Halted !== 1'b0
            || FetchCount !== 16'h0000) begin
            errors++;
            $display("FAIL reset: got pc=%h instr=%h ifpc=%h plus=%h v=%b h=%b cnt=%0d, want all zero",
                     PC, IfIdInstr, IfIdPC, IfIdPCPlus, IfIdValid, Halted, FetchCount);
        end
        Reset     = 1'b0;
        exp_pc    = 16'h0000;
        exp_count = 16'h0000;
        sb.delete();
    endtask

    task automatic test_fetch();
        test_reset();
        fetch_cycles(3, "fetch");
        checks++;
        if (PC !== 16'h000C || FetchCount !== 16'd3 || IfIdInstr !== 16'h3456) begin
            errors++;
            $display("FAIL fetch_end: got pc=%h cnt=%0d instr=%h, want 000c 3 3456",
                     PC, FetchCount, IfIdInstr);
        end
    endtask

    task automatic test_stall();
        test_reset();
        fetch_cycles(2, "pre_stall");
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (PC !== 16'h0008 || IfIdInstr !== 16'h2345 || IfIdPC !== 16'h0004
                || IfIdValid !== 1'b1 || FetchCount !== 16'd2) begin
                errors++;
                $display("FAIL stall[%0d]: got pc=%h instr=%h ifpc=%h v=%b cnt=%0d, want 0008 2345 0004 1 2",
                         i, PC, IfIdInstr, IfIdPC, IfIdValid, FetchCount);
            end
        end
        fetch_cycles(1, "post_stall");
    endtask

    task automatic test_redirect_stall();
        Redirect   = 1'b1;
        RedirectPC = 16'h0042;
        Stall      = 1'b1;
        step();
        checks++;
        if (PC !== 16'h0040 || IfIdValid !== 1'b0 || IfIdInstr !== 16'h0000
            || IfIdPC !== 16'h0000 || IfIdPCPlus !== 16'h0000 || FetchCount !== 16'd3) begin
            errors++;
            $display("FAIL redirect: got pc=%h v=%b instr=%h ifpc=%h plus=%h cnt=%0d, want 0040 0 0000 0000 0000 3",
                     PC, IfIdValid, IfIdInstr, IfIdPC, IfIdPCPlus, FetchCount);
        end
        exp_pc = 16'h0040;
        fetch_cycles(2, "after_redirect");
    endtask

    task automatic test_halt();
        test_reset();
        fetch_cycles(4, "to_halt");
        Stall = 1'b1;
        step();
        checks++;
        if (Halted !== 1'b0 || IfIdInstr !== 16'hF000 || IfIdValid !== 1'b1 || PC !== 16'h0010) begin
            errors++;
            $display("FAIL halt_stalled: got h=%b instr=%h v=%b pc=%h, want 0 f000 1 0010",
                     Halted, IfIdInstr, IfIdValid, PC);
        end
        Stall = 1'b0;
        step();
        checks++;
        if (Halted !== 1'b1 || PC !== 16'h0010 || IfIdValid !== 1'b0
            || IfIdInstr !== 16'h0000 || FetchCount !== 16'd4) begin
            errors++;
            $display("FAIL halt_commit: got h=%b pc=%h v=%b instr=%h cnt=%0d, want 1 0010 0 0000 4",
                     Halted, PC, IfIdValid, IfIdInstr, FetchCount);
        end
        Redirect   = 1'b1;
        RedirectPC = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            Stall = (i == 1);
            step();
            checks++;
            if (Halted !== 1'b1 || PC !== 16'h0010 || IfIdValid !== 1'b0 || FetchCount !== 16'd4) begin
                errors++;
                $display("FAIL halted_hold[%0d]: got h=%b pc=%h v=%b cnt=%0d, want 1 0010 0 4",
                         i, Halted, PC, IfIdValid, FetchCount);
            end
        end
        Redirect = 1'b0;
        Stall    = 1'b0;
    endtask

    task automatic test_halt_redirect();
        test_reset();
        fetch_cycles(4, "to_halt2");
        Redirect   = 1'b1;
        RedirectPC = 16'h0044;
        step();
        checks++;
        if (Halted !== 1'b0 || PC !== 16'h0044 || IfIdValid !== 1'b0) begin
            errors++;
            $display("FAIL halt_wrong_path: got h=%b pc=%h v=%b, want 0 0044 0",
                     Halted, PC, IfIdValid);
        end
        exp_pc = 16'h0044;
        fetch_cycles(1, "after_wrong_path");
    endtask

    task automatic test_wrap_and_reset();
        test_reset();
        Redirect   = 1'b1;
        RedirectPC = 16'hFFFE;
        step();
        checks++;
        if (PC !== 16'hFFFC) begin
            errors++;
            $display("FAIL redirect_high: got pc=%h, want fffc", PC);
        end
        exp_pc = 16'hFFFC;
        fetch_cycles(2, "wrap");
        Redirect   = 1'b1;
        RedirectPC = 16'h000C;
        step();
        Redirect = 1'b0;
        step();
        step();
        checks++;
        if (Halted !== 1'b1 || PC !== 16'h0010) begin
            errors++;
            $display("FAIL halt_before_reset: got h=%b pc=%h, want 1 0010", Halted, PC);
        end
        test_reset();
        fetch_cycles(1, "after_reset");
    endtask

    initial begin
        Reset      = 1'b1;
        Stall      = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 16'h0000;
        exp_pc     = 16'h0000;
        exp_count  = 16'h0000;
        test_fetch();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_halt_redirect();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
